elevator_request_queue: RTL and testbench
=========================================

Name: elevator_request_queue

Overview:
Upstream request stage for the elevator controller FSM. Synchronises and debounces the four active-low cabin buttons and four hall-call switches, latches them as sticky pending requests, and clears a floor's requests when the FSM reports it has served that floor. Supplies the FSM with a registered SCAN-order next target, plus above/below/here summaries. Floors are indexed 0..3, displayed as 1..4.

Parameters:
DEBOUNCE_CY, 1, consecutive cycles a synchronised input must differ from its debounced state before the debounced state flips (1..255).
CNT_W, 8, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CY.

Ports:
CLOCK_50  in  1  system clock, rising edge
RESET_N  in  1  asynchronous active-low reset (top level drives ~SW[17])
KEY_N  in  4  cabin buttons, active low, KEY_N[i] = go to floor i
HALL_SW  in  4  hall-call switches, active high, HALL_SW[i] = call at floor i
cur_floor  in  2  FSM current floor
dir_up  in  1  FSM travel direction, 1 = up
clr_valid  in  1  one-cycle pulse: FSM has opened the door at clr_floor
clr_floor  in  2  floor being served
pending_cab  out  4  latched cabin requests (drives LEDR)
pending_hall  out  4  latched hall requests
req_here  out  1  combinational: a request is pending at cur_floor
req_above  out  1  combinational: a request is pending at a floor > cur_floor
req_below  out  1  combinational: a request is pending at a floor < cur_floor
next_target  out  2  registered SCAN target floor
target_valid  out  1  registered: at least one request is pending

Behaviour:
- Reset (async, RESET_N low): all sync flops, debounced states, counters, pending_cab, pending_hall, next_target and target_valid go to 0. Takes effect mid-operation with no clock edge; any partial debounce is discarded.
- Input path, per bit (8 channels): invert KEY_N to active high; 2-FF synchroniser gives s2. Debounced state db plus counter: if s2 == db, the counter resets to 0. Otherwise the counter increments; when it reaches DEBOUNCE_CY, db <= s2 and the counter resets.
- Press event: db transitions 0->1. A held input generates only one event, and a new event needs a release then another press. HALL_SW is level-held but is likewise edge-triggered on its debounced rise.
- Latency: the pending bit sets on the (DEBOUNCE_CY+2)th rising edge after the raw input is first sampled active. That is 3 edges for the default, so a 1-cycle raw pulse is accepted when DEBOUNCE_CY = 1.
- Glitches shorter than DEBOUNCE_CY cycles after sync: no event.
- Set: pending_cab[i] / pending_hall[i] <= 1 on the press event.
- Clear: on clr_valid, both pending_cab[clr_floor] and pending_hall[clr_floor] <= 0 at the next edge.
- Simultaneous set and clear on the same floor in the same cycle: clear wins, because the floor is already being served. Sets on other floors are unaffected.
- Let any[i] = pending_cab[i] | pending_hall[i].
- req_above, req_below and req_here are combinational from the any[] vector and cur_floor.
- SCAN target selection, registered and updated every edge from the current any[], cur_floor and dir_up (so it lags pending by one edge):
  - dir_up=1: nearest floor above if req_above; else req_here gives cur_floor; else nearest floor below.
  - dir_up=0: nearest floor below if req_below; else req_here gives cur_floor; else nearest floor above.
  - No pending: next_target holds its last value, target_valid = 0.
- target_valid <= |any at each edge.
- No saturation or wrap concerns: 4 floors, 2-bit indices, no arithmetic beyond compares.

Test Plan:
1. Reset, DEBOUNCE_CY=1, cur_floor=0, dir_up=1; pulse KEY_N[3] low for 1 cycle. Expect pending_cab=4'b1000 at edge 3, then next_target=3 and target_valid=1 one edge later.
2. Simultaneous requests at cur_floor=0, dir_up=1: KEY_N[2]=0 and HALL_SW[1]=1 in the same cycle. Expect pending_cab=0100, pending_hall=0010, next_target=1. Then clr_valid with clr_floor=1 and cur_floor=1: expect pending_hall=0000 and next_target=2.
3. Both ends at cur_floor=2, dir_up=0: HALL_SW[0] and HALL_SW[3] together. Expect next_target=0, req_above=1, req_below=1. Then cur_floor=0 and clr at floor 0: expect next_target=3.
4. Same-floor collision at cur_floor=1: time the KEY_N[1] press event to coincide with clr_valid at clr_floor=1. Expect pending_cab[1]=0 after the edge; a second press later sets it.
5. Bounce, DEBOUNCE_CY=4: 2-cycle low glitch on KEY_N[0] gives no pending. A 6-cycle hold sets pending_cab[0] at edge 6; holding 20 more cycles gives no second event.
6. With pending=1010 and target_valid=1, assert RESET_N low mid-cycle. Expect all outputs 0 immediately, and none set after release until new presses.

Source files
------------

// File: rtl/elevator_request_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : elevator_request_queue_if
// Brief    : Request-queue <-> elevator FSM signal bundle.
// Revision : 1.0  initial release
// ============================================================================
interface elevator_request_queue_if;
    logic [1:0] cur_floor;
    logic       dir_up;
    logic       clr_valid;
    logic [1:0] clr_floor;
    logic [3:0] pending_cab;
    logic [3:0] pending_hall;
    logic       req_here;
    logic       req_above;
    logic       req_below;
    logic [1:0] next_target;
    logic       target_valid;

    // FSM side
    modport master (
        output cur_floor, dir_up, clr_valid, clr_floor,
        input  pending_cab, pending_hall, req_here, req_above, req_below,
               next_target, target_valid
    );

    // Request queue side
    modport slave (
        input  cur_floor, dir_up, clr_valid, clr_floor,
        output pending_cab, pending_hall, req_here, req_above, req_below,
               next_target, target_valid
    );
endinterface
`default_nettype wire

// File: rtl/elevator_request_queue.sv
`default_nettype none
// ============================================================================
// Module   : elevator_request_queue
// Brief    : Debounced sticky cabin/hall requests with registered SCAN target.
// Revision : 1.0  initial release
// ============================================================================
module elevator_request_queue #(
    parameter int DEBOUNCE_CY = 1,
    parameter int CNT_W       = 8
) (
    input  wire        CLOCK_50,
    input  wire        RESET_N,
    input  wire  [3:0] KEY_N,
    input  wire  [3:0] HALL_SW,
    elevator_request_queue_if.slave fsm
);
    localparam int               c_NCH      = 8;
    localparam logic [CNT_W-1:0] c_DB_LIMIT = CNT_W'(DEBOUNCE_CY);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    // Channels 0..3 are cabin buttons, 4..7 are hall calls, all active high.
    logic [c_NCH-1:0] raw;
    logic [c_NCH-1:0] sync1_q, sync1_d;
    logic [c_NCH-1:0] sync2_q, sync2_d;
    logic [c_NCH-1:0] press;

    assign raw = {HALL_SW, ~KEY_N};

    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < c_NCH; gi++) begin : g_chan
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             db_q, db_d;
            logic             flip;

            always_comb begin
                flip  = 1'b0;
                cnt_d = '0;
                db_d  = db_q;
                if (sync2_q[gi] != db_q) begin
                    if ((cnt_q + c_CNT_ONE) == c_DB_LIMIT) begin
                        flip = 1'b1;
                        db_d = sync2_q[gi];
                    end else begin
                        cnt_d = cnt_q + c_CNT_ONE;
                    end
                end
            end

            always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
                if (!RESET_N) begin
                    cnt_q <= '0;
                    db_q  <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    db_q  <= db_d;
                end
            end

            // Event fires on the same edge the debounced state rises, not a cycle later.
            assign press[gi] = flip & sync2_q[gi];
        end
    endgenerate

    logic [3:0] pend_cab_q, pend_cab_d;
    logic [3:0] pend_hall_q, pend_hall_d;

    always_comb begin
        pend_cab_d  = pend_cab_q  | press[3:0];
        pend_hall_d = pend_hall_q | press[7:4];
        // Clearing after the set lets a served floor win over a fresh press.
        if (fsm.clr_valid) begin
            pend_cab_d[fsm.clr_floor]  = 1'b0;
            pend_hall_d[fsm.clr_floor] = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            pend_cab_q  <= '0;
            pend_hall_q <= '0;
        end else begin
            pend_cab_q  <= pend_cab_d;
            pend_hall_q <= pend_hall_d;
        end
    end

    logic [3:0] any_req;
    logic       above, below, here;
    logic [1:0] near_above, near_below;

    assign any_req = pend_cab_q | pend_hall_q;

    always_comb begin
        above      = 1'b0;
        below      = 1'b0;
        near_above = 2'd0;
        near_below = 2'd0;
        here       = any_req[fsm.cur_floor];
        // Descending scan leaves the lowest floor above; ascending the highest below.
        for (int i = 3; i >= 0; i--) begin
            if (any_req[i] && (2'(i) > fsm.cur_floor)) begin
                above      = 1'b1;
                near_above = 2'(i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (any_req[i] && (2'(i) < fsm.cur_floor)) begin
                below      = 1'b1;
                near_below = 2'(i);
            end
        end
    end

    logic [1:0] target_q, target_d;
    logic       valid_q, valid_d;

    always_comb begin
        target_d = target_q;
        valid_d  = |any_req;
        if (fsm.dir_up) begin
            if (above)      target_d = near_above;
            else if (here)  target_d = fsm.cur_floor;
            else if (below) target_d = near_below;
        end else begin
            if (below)      target_d = near_below;
            else if (here)  target_d = fsm.cur_floor;
            else if (above) target_d = near_above;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            target_q <= 2'd0;
            valid_q  <= 1'b0;
        end else begin
            target_q <= target_d;
            valid_q  <= valid_d;
        end
    end

    assign fsm.pending_cab  = pend_cab_q;
    assign fsm.pending_hall = pend_hall_q;
    assign fsm.req_here     = here;
    assign fsm.req_above    = above;
    assign fsm.req_below    = below;
    assign fsm.next_target  = target_q;
    assign fsm.target_valid = valid_q;
endmodule
`default_nettype wire

// File: tb/tb_elevator_request_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_elevator_request_queue
// Brief    : Vector table with scoreboard queue plus reset/debounce sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_elevator_request_queue;
    logic       CLOCK_50 = 1'b0;
    logic       RESET_N;
    logic [3:0] KEY_N;
    logic [3:0] HALL_SW;
    logic [1:0] cur_floor;
    logic       dir_up;
    logic       clr_valid;
    logic [1:0] clr_floor;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    elevator_request_queue_if ifa ();
    elevator_request_queue_if ifb ();

    assign ifa.cur_floor = cur_floor;
    assign ifa.dir_up    = dir_up;
    assign ifa.clr_valid = clr_valid;
    assign ifa.clr_floor = clr_floor;
    assign ifb.cur_floor = cur_floor;
    assign ifb.dir_up    = dir_up;
    assign ifb.clr_valid = clr_valid;
    assign ifb.clr_floor = clr_floor;

    elevator_request_queue #(.DEBOUNCE_CY(1), .CNT_W(8)) u_dut_a (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .KEY_N    (KEY_N),
        .HALL_SW  (HALL_SW),
        .fsm      (ifa)
    );

    elevator_request_queue #(.DEBOUNCE_CY(4), .CNT_W(8)) u_dut_b (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .KEY_N    (KEY_N),
        .HALL_SW  (HALL_SW),
        .fsm      (ifb)
    );

    // {cab, hall, target, valid, above, below, here}
    logic [13:0] a_out, b_out;
    assign a_out = {ifa.pending_cab, ifa.pending_hall, ifa.next_target,
                    ifa.target_valid, ifa.req_above, ifa.req_below, ifa.req_here};
    assign b_out = {ifb.pending_cab, ifb.pending_hall, ifb.next_target,
                    ifb.target_valid, ifb.req_above, ifb.req_below, ifb.req_here};

    typedef struct {
        string       name;
        logic [3:0]  key_n;
        logic [3:0]  hall;
        logic [1:0]  cur;
        logic        dir;
        logic        clr_v;
        logic [1:0]  clr_f;
        int          edges;
        logic [13:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [13:0] sb_exp[$];
    string       sb_name[$];

    function automatic logic [13:0] pk(input logic [3:0] cab, input logic [3:0] hl,
                                       input logic [1:0] tgt, input logic tv,
                                       input logic ab, input logic be, input logic he);
        return {cab, hl, tgt, tv, ab, be, he};
    endfunction

    function automatic vec_t mk(input string nm, input logic [3:0] kn, input logic [3:0] hl,
                                input logic [1:0] cf, input logic dr, input logic cv,
                                input logic [1:0] cfl, input int ed, input logic [13:0] ex);
        vec_t v;
        v.name = nm; v.key_n = kn; v.hall = hl; v.cur = cf; v.dir = dr;
        v.clr_v = cv; v.clr_f = cfl; v.edges = ed; v.exp = ex;
        return v;
    endfunction

    task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h want 0x%h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        logic [13:0] e;
        string       n;
        KEY_N     = v.key_n;
        HALL_SW   = v.hall;
        cur_floor = v.cur;
        dir_up    = v.dir;
        clr_valid = v.clr_v;
        clr_floor = v.clr_f;
        sb_exp.push_back(v.exp);
        sb_name.push_back(v.name);
        repeat (v.edges) @(negedge CLOCK_50);
        e = sb_exp.pop_front();
        n = sb_name.pop_front();
        chk(n, a_out, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0; KEY_N = 4'hF; HALL_SW = 4'h0;
        cur_floor = 2'd0; dir_up = 1'b1; clr_valid = 1'b0; clr_floor = 2'd0;

        //               name          key_n  hall  cur  dir cv  cf  ed   cab  hall tgt tv ab be he
        vecs.push_back(mk("idle",       4'hF, 4'h0, 2'd0, 1, 0, 2'd0, 1, pk(4'h0,4'h0,2'd0,0,0,0,0)));
        vecs.push_back(mk("t1_press",   4'h7, 4'h0, 2'd0, 1, 0, 2'd0, 1, pk(4'h0,4'h0,2'd0,0,0,0,0)));
        vecs.push_back(mk("t1_rel",     4'hF, 4'h0, 2'd0, 1, 0, 2'd0, 1, pk(4'h0,4'h0,2'd0,0,0,0,0)));
        vecs.push_back(mk("t1_edge3",   4'hF, 4'h0, 2'd0, 1, 0, 2'd0, 1, pk(4'h8,4'h0,2'd0,0,1,0,0)));
        vecs.push_back(mk("t1_tgt",     4'hF, 4'h0, 2'd0, 1, 0, 2'd0, 1, pk(4'h8,4'h0,2'd3,1,1,0,0)));
        vecs.push_back(mk("t1_clr3",    4'hF, 4'h0, 2'd3, 1, 1, 2'd3, 1, pk(4'h0,4'h0,2'd3,1,0,0,0)));
        vecs.push_back(mk("t1_idle",    4'hF, 4'h0, 2'd0, 1, 0, 2'd0, 1, pk(4'h0,4'h0,2'd3,0,0,0,0)));
        vecs.push_back(mk("t2_press",   4'hB, 4'h2, 2'd0, 1, 0, 2'd0, 1, pk(4'h0,4'h0,2'd3,0,0,0,0)));
        vecs.push_back(mk("t2_edge3",   4'hF, 4'h2, 2'd0, 1, 0, 2'd0, 2, pk(4'h4,4'h2,2'd3,0,1,0,0)));
        vecs.push_back(mk("t2_tgt",     4'hF, 4'h2, 2'd0, 1, 0, 2'd0, 1, pk(4'h4,4'h2,2'd1,1,1,0,0)));
        vecs.push_back(mk("t2_clr1",    4'hF, 4'h2, 2'd1, 1, 1, 2'd1, 1, pk(4'h4,4'h0,2'd2,1,1,0,0)));
        vecs.push_back(mk("t2_held",    4'hF, 4'h2, 2'd1, 1, 0, 2'd0, 3, pk(4'h4,4'h0,2'd2,1,1,0,0)));
        vecs.push_back(mk("t2_rel",     4'hF, 4'h0, 2'd1, 1, 0, 2'd0, 3, pk(4'h4,4'h0,2'd2,1,1,0,0)));
        vecs.push_back(mk("t2_clr2",    4'hF, 4'h0, 2'd2, 1, 1, 2'd2, 1, pk(4'h0,4'h0,2'd2,1,0,0,0)));
        vecs.push_back(mk("t3_press",   4'hF, 4'h9, 2'd2, 0, 0, 2'd0, 3, pk(4'h0,4'h9,2'd2,0,1,1,0)));
        vecs.push_back(mk("t3_tgt",     4'hF, 4'h9, 2'd2, 0, 0, 2'd0, 1, pk(4'h0,4'h9,2'd0,1,1,1,0)));
        vecs.push_back(mk("t3_clr0",    4'hF, 4'h9, 2'd0, 0, 1, 2'd0, 1, pk(4'h0,4'h8,2'd0,1,1,0,0)));
        vecs.push_back(mk("t3_tgt3",    4'hF, 4'h9, 2'd0, 0, 0, 2'd0, 1, pk(4'h0,4'h8,2'd3,1,1,0,0)));
        vecs.push_back(mk("t3_rel",     4'hF, 4'h0, 2'd0, 0, 0, 2'd0, 3, pk(4'h0,4'h8,2'd3,1,1,0,0)));
        vecs.push_back(mk("t3_clr3",    4'hF, 4'h0, 2'd3, 0, 1, 2'd3, 1, pk(4'h0,4'h0,2'd3,1,0,0,0)));
        vecs.push_back(mk("t4_idle",    4'hF, 4'h0, 2'd1, 1, 0, 2'd0, 1, pk(4'h0,4'h0,2'd3,0,0,0,0)));
        vecs.push_back(mk("t4_press",   4'hC, 4'h0, 2'd1, 1, 0, 2'd0, 1, pk(4'h0,4'h0,2'd3,0,0,0,0)));
        vecs.push_back(mk("t4_rel",     4'hF, 4'h0, 2'd1, 1, 0, 2'd0, 1, pk(4'h0,4'h0,2'd3,0,0,0,0)));
        vecs.push_back(mk("t4_collide", 4'hF, 4'h0, 2'd1, 1, 1, 2'd1, 1, pk(4'h1,4'h0,2'd3,0,0,1,0)));
        vecs.push_back(mk("t4_tgt",     4'hF, 4'h0, 2'd1, 1, 0, 2'd0, 1, pk(4'h1,4'h0,2'd0,1,0,1,0)));
        vecs.push_back(mk("t4_press2",  4'hD, 4'h0, 2'd1, 1, 0, 2'd0, 1, pk(4'h1,4'h0,2'd0,1,0,1,0)));
        vecs.push_back(mk("t4_set2",    4'hF, 4'h0, 2'd1, 1, 0, 2'd0, 2, pk(4'h3,4'h0,2'd0,1,0,1,1)));
        vecs.push_back(mk("t4_tgt2",    4'hF, 4'h0, 2'd1, 1, 0, 2'd0, 1, pk(4'h3,4'h0,2'd1,1,0,1,1)));
        vecs.push_back(mk("t6_clr0",    4'hF, 4'h0, 2'd1, 1, 1, 2'd0, 1, pk(4'h2,4'h0,2'd1,1,0,0,1)));
        vecs.push_back(mk("t6_press",   4'h7, 4'h0, 2'd1, 1, 0, 2'd0, 1, pk(4'h2,4'h0,2'd1,1,0,0,1)));
        vecs.push_back(mk("t6_set",     4'hF, 4'h0, 2'd1, 1, 0, 2'd0, 2, pk(4'hA,4'h0,2'd1,1,1,0,1)));

        #3;
        chk("reset_a", a_out, 14'h0);
        chk("reset_b", b_out, 14'h0);
        repeat (3) @(negedge CLOCK_50);
        RESET_N = 1'b1;

        foreach (vecs[i]) step(vecs[i]);

        // Asynchronous reset between edges with 1010 pending.
        #2;
        RESET_N = 1'b0;
        #1;
        chk("midreset_a", a_out, 14'h0);
        chk("midreset_b_pend", {6'd0, b_out[13:10], 4'd0}, 14'h0);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        repeat (8) @(negedge CLOCK_50);
        chk("postreset_quiet", a_out, 14'h0);

        // DEBOUNCE_CY = 4: short glitch rejected, long hold accepted once.
        KEY_N = 4'hE;
        repeat (2) @(negedge CLOCK_50);
        KEY_N = 4'hF;
        repeat (10) @(negedge CLOCK_50);
        chk("t5_glitch", {10'd0, b_out[13:10]}, 14'h0);
        KEY_N = 4'hE;
        repeat (5) @(negedge CLOCK_50);
        chk("t5_edge5", {10'd0, b_out[13:10]}, 14'h0);
        @(negedge CLOCK_50);
        chk("t5_edge6", {10'd0, b_out[13:10]}, 14'h1);
        clr_valid = 1'b1;
        clr_floor = 2'd0;
        @(negedge CLOCK_50);
        clr_valid = 1'b0;
        chk("t5_clr", {10'd0, b_out[13:10]}, 14'h0);
        repeat (20) @(negedge CLOCK_50);
        chk("t5_held", {10'd0, b_out[13:10]}, 14'h0);
        KEY_N = 4'hF;
        repeat (8) @(negedge CLOCK_50);
        chk("t5_release", {10'd0, b_out[13:10]}, 14'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
